pwm_deadtime: RTL and testbench

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_deadtime_pkg.sv | 13 +
 rtl/pwm_deadtime_if.sv | 27 ++
 rtl/pwm_dt_phase.sv | 82 ++++++++
 rtl/pwm_deadtime.sv | 64 ++++++
 tb/tb_pwm_deadtime.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pwm_deadtime_pkg.sv
// rtl/pwm_deadtime_pkg.sv - shared state encodings and defaults for the dead-time PWM block
package pwm_deadtime_pkg;

    localparam int DT_WIDTH_DEF = 8;

    typedef logic [1:0] dt_state_t;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;
    localparam logic [1:0] ST_DEAD = 2'd3;

endpackage

// File: rtl/pwm_deadtime_if.sv
// rtl/pwm_deadtime_if.sv - command and gate-drive signal bundle for pwm_deadtime
interface pwm_deadtime_if
    import pwm_deadtime_pkg::*;
#(
    parameter int PHASES   = 1,
    parameter int DT_WIDTH = DT_WIDTH_DEF
);
    logic                ena;
    logic [PHASES-1:0]   pwm_in;
    logic [DT_WIDTH-1:0] dead_cycles;
    logic                fault;
    logic                fault_clr;
    logic [PHASES-1:0]   gate_hi;
    logic [PHASES-1:0]   gate_lo;
    logic [PHASES-1:0]   dead_active;
    logic                fault_latched;

    modport master (
        output ena, pwm_in, dead_cycles, fault, fault_clr,
        input  gate_hi, gate_lo, dead_active, fault_latched
    );

    modport slave (
        input  ena, pwm_in, dead_cycles, fault, fault_clr,
        output gate_hi, gate_lo, dead_active, fault_latched
    );
endinterface

// File: rtl/pwm_dt_phase.sv
// rtl/pwm_dt_phase.sv - one phase: OFF/HI/LO/DEAD state machine with dead-time counter
module pwm_dt_phase
    import pwm_deadtime_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_i,
    input  logic                pwm_i,
    input  logic [DT_WIDTH-1:0] dead_cycles_i,
    output logic                gate_hi_o,
    output logic                gate_lo_o,
    output logic                dead_active_o
);

    dt_state_t           state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DT_WIDTH-1:0] dt_load;
    logic                gate_hi_q, gate_lo_q, dead_q;

    assign dt_load = (dead_cycles_i == '0) ? DT_WIDTH'(1) : dead_cycles_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run_i) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_DEAD;
                    cnt_d   = dt_load;
                end
                ST_HI: begin
                    if (!pwm_i) begin
                        state_d = ST_DEAD;
                        cnt_d   = dt_load;
                    end
                end
                ST_LO: begin
                    if (pwm_i) begin
                        state_d = ST_DEAD;
                        cnt_d   = dt_load;
                    end
                end
                default: begin
                    // Command toggles inside DEAD only matter at expiry.
                    if (cnt_q <= DT_WIDTH'(1)) begin
                        state_d = pwm_i ? ST_HI : ST_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    // Gate flops are loaded from the next state so they switch with the FSM, glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_hi_q <= (state_d == ST_HI);
            gate_lo_q <= (state_d == ST_LO);
            dead_q    <= (state_d == ST_DEAD);
        end
    end

    assign gate_hi_o     = gate_hi_q;
    assign gate_lo_o     = gate_lo_q;
    assign dead_active_o = dead_q;

endmodule

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - multi-phase PWM dead-time inserter with synchronized, latched fault shutdown
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int PHASES   = 1,
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pwm_deadtime_if.slave  bus
);

    logic [PHASES-1:0] pwm_q;
    logic              fault_meta_q, fault_sync_q;
    logic              fault_latched_q, fault_latched_d;
    logic              run;
    logic [PHASES-1:0] gate_hi_w, gate_lo_w, dead_w;

    always_comb begin
        fault_latched_d = fault_latched_q;
        if (fault_sync_q)
            fault_latched_d = 1'b1;
        else if (bus.fault_clr)
            fault_latched_d = 1'b0;
    end

    // A synchronized fault stops the phases on the same edge that sets the latch.
    assign run = bus.ena & ~(fault_latched_q | fault_sync_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q           <= '0;
            fault_meta_q    <= 1'b0;
            fault_sync_q    <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            pwm_q           <= bus.pwm_in;
            fault_meta_q    <= bus.fault;
            fault_sync_q    <= fault_meta_q;
            fault_latched_q <= fault_latched_d;
        end
    end

    for (genvar g = 0; g < PHASES; g++) begin : g_phase
        pwm_dt_phase #(
            .DT_WIDTH (DT_WIDTH)
        ) u_phase (
            .clk           (clk),
            .rst           (rst),
            .run_i         (run),
            .pwm_i         (pwm_q[g]),
            .dead_cycles_i (bus.dead_cycles),
            .gate_hi_o     (gate_hi_w[g]),
            .gate_lo_o     (gate_lo_w[g]),
            .dead_active_o (dead_w[g])
        );
    end

    assign bus.gate_hi       = gate_hi_w;
    assign bus.gate_lo       = gate_lo_w;
    assign bus.dead_active   = dead_w;
    assign bus.fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb/tb_pwm_deadtime.sv - directed self-checking bench for pwm_deadtime
module tb_pwm_deadtime;
    import pwm_deadtime_pkg::*;

    localparam int PHASES = 3;
    localparam int DTW    = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic hi_seen;

    pwm_deadtime_if #(.PHASES(PHASES), .DT_WIDTH(DTW)) bus ();

    pwm_deadtime #(
        .PHASES   (PHASES),
        .DT_WIDTH (DTW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.ena         = 1'b0;
        bus.pwm_in      = '0;
        bus.dead_cycles = 8'd4;
        bus.fault       = 1'b0;
        bus.fault_clr   = 1'b0;
        step(2);
        check("rst_hi",    32'(bus.gate_hi), 0);
        check("rst_lo",    32'(bus.gate_lo), 0);
        check("rst_dead",  32'(bus.dead_active), 0);
        check("rst_fault", 32'(bus.fault_latched), 0);

        // Reset release with enable: full 4-cycle DEAD, then LO
        rst     = 1'b0;
        bus.ena = 1'b1;
        step(1);
        check("start_dead", 32'(bus.dead_active), 32'h7);
        check("start_lo0",  32'(bus.gate_lo), 0);
        step(3);
        check("start_dead4", 32'(bus.dead_active), 32'h7);
        step(1);
        check("start_lo", 32'(bus.gate_lo), 32'h7);

        // Rising command on phase 0, D=4
        bus.pwm_in = 3'b001;
        step(1);
        check("rise_lo_hold", 32'(bus.gate_lo), 32'h7);
        step(1);
        check("rise_lo_off", 32'(bus.gate_lo), 32'h6);
        check("rise_dead",   32'(bus.dead_active), 32'h1);
        step(3);
        check("rise_hi_early", 32'(bus.gate_hi), 0);
        step(1);
        check("rise_hi_on", 32'(bus.gate_hi), 32'h1);

        // Falling command, symmetric
        bus.pwm_in = 3'b000;
        step(1);
        check("fall_hi_hold", 32'(bus.gate_hi), 32'h1);
        step(1);
        check("fall_hi_off", 32'(bus.gate_hi), 0);
        check("fall_dead",   32'(bus.dead_active), 32'h1);
        step(3);
        check("fall_lo_early", 32'(bus.gate_lo), 32'h6);
        step(1);
        check("fall_lo_on", 32'(bus.gate_lo), 32'h7);

        // 2-cycle glitch while LO with D=5; dead_cycles change inside DEAD ignored
        bus.dead_cycles = 8'd5;
        hi_seen         = 1'b0;
        bus.pwm_in      = 3'b001;
        step(1);
        hi_seen |= bus.gate_hi[0];
        step(1);
        hi_seen |= bus.gate_hi[0];
        check("glitch_dead", 32'(bus.dead_active), 32'h1);
        bus.pwm_in      = 3'b000;
        step(1);
        hi_seen |= bus.gate_hi[0];
        bus.dead_cycles = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            hi_seen |= bus.gate_hi[0];
        end
        check("glitch_dead5", 32'(bus.dead_active), 32'h1);
        step(1);
        hi_seen |= bus.gate_hi[0];
        check("glitch_back_lo", 32'(bus.gate_lo), 32'h7);
        check("glitch_no_hi",   32'(hi_seen), 0);

        // dead_cycles=0 behaves as a single dead cycle
        bus.dead_cycles = 8'd0;
        bus.pwm_in      = 3'b001;
        step(2);
        check("dt0_dead", 32'(bus.dead_active), 32'h1);
        step(1);
        check("dt0_hi", 32'(bus.gate_hi), 32'h1);

        // Random commands on all phases: never both gates on
        for (int i = 0; i < 200; i++) begin
            bus.pwm_in = 3'($urandom_range(0, 7));
            step(1);
            check("no_overlap", 32'(bus.gate_hi & bus.gate_lo), 0);
        end

        // Fault while HI, D=3
        bus.dead_cycles = 8'd3;
        bus.pwm_in      = 3'b111;
        step(10);
        check("pre_fault_hi", 32'(bus.gate_hi), 32'h7);
        bus.fault = 1'b1;
        step(2);
        check("fault_sync_hi", 32'(bus.gate_hi), 32'h7);
        step(1);
        check("fault_off_hi",  32'(bus.gate_hi), 0);
        check("fault_off_lo",  32'(bus.gate_lo), 0);
        check("fault_latched", 32'(bus.fault_latched), 1);
        bus.fault_clr = 1'b1;
        step(1);
        check("fault_clr_ignored", 32'(bus.fault_latched), 1);
        bus.fault_clr = 1'b0;
        bus.fault     = 1'b0;
        step(2);
        check("fault_still_latched", 32'(bus.fault_latched), 1);
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        check("fault_cleared",  32'(bus.fault_latched), 0);
        check("fault_clr_gate", 32'(bus.gate_hi | bus.gate_lo), 0);
        step(1);
        check("refault_dead", 32'(bus.dead_active), 32'h7);
        step(2);
        check("refault_hi_early", 32'(bus.gate_hi), 0);
        step(1);
        check("refault_hi", 32'(bus.gate_hi), 32'h7);

        // Reset mid-DEAD, D=4
        bus.dead_cycles = 8'd4;
        bus.pwm_in      = 3'b000;
        step(2);
        check("pre_rst_dead", 32'(bus.dead_active), 32'h7);
        step(1);
        rst = 1'b1;
        step(1);
        check("mid_rst_gates", 32'(bus.gate_hi | bus.gate_lo), 0);
        check("mid_rst_dead",  32'(bus.dead_active), 0);
        rst = 1'b0;
        step(1);
        check("post_rst_dead", 32'(bus.dead_active), 32'h7);
        step(3);
        check("post_rst_gates", 32'(bus.gate_hi | bus.gate_lo), 0);
        step(1);
        check("post_rst_lo", 32'(bus.gate_lo), 32'h7);

        // Enable dropped mid-HI
        bus.pwm_in = 3'b111;
        step(6);
        check("pre_ena_hi", 32'(bus.gate_hi), 32'h7);
        bus.ena = 1'b0;
        step(1);
        check("ena_off_gates", 32'(bus.gate_hi | bus.gate_lo), 0);
        check("ena_off_dead",  32'(bus.dead_active), 0);
        bus.ena = 1'b1;
        step(1);
        check("reena_dead", 32'(bus.dead_active), 32'h7);
        step(3);
        check("reena_hi_early", 32'(bus.gate_hi), 0);
        step(1);
        check("reena_hi", 32'(bus.gate_hi), 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
